// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed/unsigned multiply (radix-2 Booth) and restoring divide.
// One operation in flight; hi/lo are latched together with a one-cycle done pulse.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned NW = WIDTH + 1;
   localparam int unsigned AW = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned BW = AW + NW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [NW-1:0]    qr_q, qr_d;
   logic             qm1_q, qm1_d;
   logic [NW-1:0]    m_q, m_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [BW-1:0]      booth_res;
   logic [2*WIDTH-1:0] div_res;
   logic [WIDTH-1:0]   quo, rem;
   logic               sgn;

   function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] x);
      return n ? WIDTH'(~x + 1'b1) : x;
   endfunction

   // One Booth iteration: add/sub multiplicand, then arithmetic shift of {acc, q, q-1}.
   function automatic logic [BW-1:0] booth_step(input logic [AW-1:0] acc, input logic [NW-1:0] q,
                                                input logic qm1, input logic [NW-1:0] m);
      logic [AW-1:0] mx;
      logic [AW-1:0] sum;
      mx = {m[NW-1], m};
      case ({q[0], qm1})
         2'b01:   sum = acc + mx;
         2'b10:   sum = acc - mx;
         default: sum = acc;
      endcase
      return {sum[AW-1], sum, q};
   endfunction

   // One restoring-division iteration; returns {remainder, quotient/dividend}.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d);
      logic [WIDTH:0] sh;
      logic [WIDTH:0] trial;
      sh    = {r, q[WIDTH-1]};
      trial = sh - {1'b0, d};
      if (!trial[WIDTH]) return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
      return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
   endfunction

   always_comb begin
      booth_res = booth_step(acc_q, qr_q, qm1_q, m_q);
      div_res   = div_step(acc_q[WIDTH-1:0], qr_q[WIDTH-1:0], m_q[WIDTH-1:0]);
      quo       = neg_if(qneg_q, qr_q[WIDTH-1:0]);
      rem       = neg_if(rneg_q, acc_q[WIDTH-1:0]);
      sgn       = ~op[0];

      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      a_d      = a_q;
      acc_d    = acc_q;
      qr_d     = qr_q;
      qm1_d    = qm1_q;
      m_d      = m_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               busy_d   = 1'b1;
               dz_d     = 1'b0;
               cnt_d    = CW'(WIDTH);
               is_div_d = op[1];
               a_d      = a;
               acc_d    = '0;
               qm1_d    = 1'b0;
               if (op[1]) begin
                  qr_d   = {1'b0, neg_if(sgn & a[WIDTH-1], a)};
                  m_d    = {1'b0, neg_if(sgn & b[WIDTH-1], b)};
                  qneg_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rneg_d = sgn & a[WIDTH-1];
               end else begin
                  qr_d   = {sgn & b[WIDTH-1], b};
                  m_d    = {sgn & a[WIDTH-1], a};
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end
            end
         end
         S_RUN: begin
            if (is_div_q) begin
               acc_d = {2'b00, div_res[2*WIDTH-1:WIDTH]};
               qr_d  = {1'b0, div_res[WIDTH-1:0]};
            end else begin
               {acc_d, qr_d, qm1_d} = booth_res;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FINISH;
         end
         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (is_div_q) begin
               if (m_q[WIDTH-1:0] == '0) begin
                  dz_d = 1'b1;
                  hi_d = a_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               // The (WIDTH+1)-th Booth iteration happens here, straight into hi/lo.
               {acc_d, qr_d, qm1_d} = booth_res;
               hi_d = booth_res[2*WIDTH:WIDTH+1];
               lo_d = booth_res[WIDTH:1];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         a_q      <= '0;
         acc_q    <= '0;
         qr_q     <= '0;
         qm1_q    <= 1'b0;
         m_q      <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         qr_q     <= qr_d;
         qm1_q    <= qm1_d;
         m_q      <= m_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: scoreboard of expected hi/lo/div_zero, checked on done.
module tb_mult_div_unit;

   localparam int unsigned W  = 32;
   localparam int unsigned W8 = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, dz;
   logic [W-1:0] hi, lo;

   logic          s_start;
   logic [1:0]    s_op;
   logic [W8-1:0] s_a, s_b;
   logic          s_busy, s_done, s_dz;
   logic [W8-1:0] s_hi, s_lo;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(dz), .hi(hi), .lo(lo)
   );

   mult_div_unit #(.WIDTH(W8)) dut8 (
      .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
      .busy(s_busy), .done(s_done), .div_zero(s_dz), .hi(s_hi), .lo(s_lo)
   );

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference results from 64-bit integer arithmetic.
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint sx, sy, p, q, r;
      sx   = o[0] ? longint'(x) : longint'(signed'(x));
      sy   = o[0] ? longint'(y) : longint'(signed'(y));
      e.dz = 1'b0;
      if (!o[1]) begin
         p    = sx * sy;
         e.hi = p[2*W-1:W];
         e.lo = p[W-1:0];
      end else if (y == '0) begin
         e.dz = 1'b1;
         e.hi = x;
         e.lo = '1;
      end else begin
         q    = sx / sy;
         r    = sx % sy;
         e.hi = r[W-1:0];
         e.lo = q[W-1:0];
      end
      return e;
   endfunction

   // Called at a negedge: drive the request and record its expected result.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_q.push_back(model(o, x, y));
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
   endtask

   // Wait (bounded) for done, check latency/busy, then pop and compare; optional stray start at poke.
   task automatic wait_done(input string tag, input int poke);
      int           n  = 0;
      int           nb = 0;
      exp_t         e;
      logic [W-1:0] lo_hold;
      lo_hold = lo;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (busy) nb++;
         if (poke != 0 && n == poke) begin
            check({tag, " lo held during run"}, lo, lo_hold);
            start = 1'b1;
            op    = 2'b11;
            a     = 32'h0000_1234;
            b     = 32'h0000_0005;
         end
         if (poke != 0 && n == poke + 1) start = 1'b0;
      end while (!done && n < 200);
      check({tag, " latency"}, n, W + 2);
      check({tag, " busy cycles"}, nb, W + 1);
      check({tag, " busy in done"}, busy, 1'b0);
      check({tag, " sb nonempty"}, exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, " hi"}, hi, e.hi);
         check({tag, " lo"}, lo, e.lo);
         check({tag, " div_zero"}, dz, e.dz);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ndone;
      reset   = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      a       = '0;
      b       = '0;
      s_start = 1'b0;
      s_op    = 2'b00;
      s_a     = '0;
      s_b     = '0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset div_zero", dz, 1'b0);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
      wait_done("mult -3*7", 0);
      check("mult -3*7 hi const", hi, 32'hFFFF_FFFF);
      check("mult -3*7 lo const", lo, 32'hFFFF_FFEB);
      @(negedge clk);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu ff*ff", 0);
      check("multu ff*ff hi const", hi, 32'hFFFF_FFFE);
      @(negedge clk);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mult -1*-1", 0);
      @(negedge clk);

      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done("div -7/2", 0);
      check("div -7/2 lo const", lo, 32'hFFFF_FFFD);
      @(negedge clk);
      issue(2'b11, 32'd100, 32'd7);
      wait_done("divu 100/7", 0);
      @(negedge clk);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div min/-1", 0);
      check("div min/-1 lo const", lo, 32'h8000_0000);
      @(negedge clk);

      issue(2'b11, 32'h0000_0010, 32'h0);
      wait_done("divu by zero", 0);
      @(negedge clk);
      issue(2'b00, 32'd2, 32'd3);
      wait_done("mult 2*3 after dz", 0);
      @(negedge clk);

      issue(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
      wait_done("mult stray start", 5);
      ndone = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("stray start not queued", ndone, 0);

      issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1001);
      wait_done("b2b first", 0);
      issue(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
      wait_done("b2b second", 0);
      issue(2'b11, 32'hCAFE_F00D, 32'h0001_0003);
      wait_done("b2b third", 0);
      @(negedge clk);

      start = 1'b1;
      op    = 2'b00;
      a     = 32'd5;
      b     = 32'd9;
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      check("midop reset busy", busy, 1'b0);
      check("midop reset done", done, 1'b0);
      check("midop reset hi", hi, 32'h0);
      check("midop reset lo", lo, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("no done after reset", ndone, 0);
      issue(2'b00, 32'd6, 32'd7);
      wait_done("mult 6*7 after reset", 0);
      @(negedge clk);

      s_start = 1'b1;
      s_op    = 2'b00;
      s_a     = 8'h80;
      s_b     = 8'h80;
      n       = 0;
      do begin
         @(negedge clk);
         n++;
         s_start = 1'b0;
      end while (!s_done && n < 100);
      check("w8 latency", n, W8 + 2);
      check("w8 hi", s_hi, 8'h40);
      check("w8 lo", s_lo, 8'h00);
      check("w8 div_zero", s_dz, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
